rr_stream_mux: RTL
==================

Name: rr_stream_mux

Overview:
Parametrised successor to the team's 2:1 select muxes. Merges N_CH valid/ready input streams of WIDTH bits onto one registered output stream. Selection is round-robin or fixed-priority, chosen by parameter. Output carries the source channel index. Sits between multiple producers and a single shared consumer, e.g. a shared bus or logging port.

Parameters:
N_CH, 4, number of input channels; legal range 2..16.
WIDTH, 8, data width per channel in bits; must be >= 1.
MODE, 0, arbitration mode: 0 = round-robin; 1 = fixed priority (lowest index wins).
CHW, $clog2(N_CH), width of the channel index; derived, never overridden.

Ports:
clk  input  1  rising-edge clock.
areset_n  input  1  asynchronous active-low reset.
in_valid  input  N_CH  per-channel valid; bit i belongs to channel i.
in_data  input  N_CH*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
in_ready  output  N_CH  per-channel ready; one-hot or zero.
out_valid  output  1  output register holds a word.
out_data  output  WIDTH  registered selected data.
out_ch  output  CHW  index of the channel that supplied out_data.
out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (areset_n low, asserted asynchronously, released synchronously to clk):
  - out_valid=0, out_data=0, out_ch=0.
  - RR pointer ptr=0.
  - in_ready is all zeros while reset is held.
- Internal signal can_load = ~out_valid | out_ready. This gives a full-throughput single-stage pipeline.
- Grant, combinational from in_valid and ptr:
  - MODE 0: first asserted in_valid searching ptr, ptr+1, … wrapping modulo N_CH.
  - MODE 1: lowest asserted index; ptr is ignored.
  - No valid inputs: no grant.
- in_ready[i] = grant[i] & can_load. At most one bit is set. in_ready never depends on out_valid alone when out_ready=1.
- Input transfer on channel g: in_valid[g] & in_ready[g]. On that clk edge:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
  - MODE 0 only: ptr <= (g == N_CH-1) ? 0 : g+1
- Output transfer: out_valid & out_ready.
  - If no input transfer on the same edge: out_valid <= 0. out_data and out_ch hold their values.
  - If an input transfer happens on the same edge: the register reloads and out_valid stays 1. No bubble.
- Latency: one cycle from input transfer to out_valid. Sustained throughput is 1 word/cycle.
- Backpressure: while out_valid & ~out_ready, out_data and out_ch are stable, and all in_ready are 0.
- Fairness, MODE 0: with all channels continuously valid and out_ready=1, grants cycle 0,1,…,N_CH-1,0. Any requesting channel waits at most N_CH-1 transfers.
- ptr advances only on an actual input transfer. A grant without a transfer (blocked by backpressure) does not move ptr.
- Inputs may drop in_valid without a transfer. Grant re-evaluates every cycle; no lock is held.
- Non-power-of-2 N_CH: the pointer wraps at N_CH-1 → 0. out_ch never exceeds N_CH-1.
- Reset mid-stream: a held word is discarded, out_valid drops immediately (asynchronous), and ptr returns to 0.
- No combinational path from in_data to out_data.

Test Plan:
- Reset: hold areset_n=0 with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=0. Release; next edge loads channel 0.
- MODE 0, N_CH=4, all valid, in_data[i]=8'hA0+i, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3 with out_data A0,A1,A2,A3,…, one word per cycle.
- MODE 0, only ch2 and ch3 valid, ptr=3 → ch3 granted first, then ch2, then ch3. ch0 and ch1 in_ready stay 0.
- Backpressure: out_valid=1 holding 8'h5C from ch1, out_ready=0 for 3 cycles → out_data=5C and out_ch=1 stable, in_ready=0, ptr unchanged. Then out_ready=1 → the next word loads on the same edge with no bubble.
- MODE 1, N_CH=3, ch0 and ch2 valid continuously → out_ch always 0 and ch2 starves. Drop ch0 → ch2 is granted the next cycle.
- Async reset asserted mid-cycle while out_valid=1 → out_valid falls before the next clk edge. After release, the first grant comes from ptr=0.

Source files
------------

// File: rtl/rr_stream_mux_if.sv
// Stream bundle between N_CH producers, the merging mux and a single consumer.
// The master side drives the input streams and consumer ready; the slave side is the mux.
interface rr_stream_mux_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int CHW = $clog2(N_CH);

  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [CHW-1:0]        out_ch;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_stream_mux.sv
// Merges N_CH valid/ready streams onto one registered output stream tagged with the
// source channel; round-robin (MODE 0) or lowest-index-first (MODE 1) arbitration.
module rr_stream_mux #(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  parameter  int MODE  = 0,
  localparam int CHW   = $clog2(N_CH)
) (
  input  logic          clk,
  input  logic          areset_n,
  rr_stream_mux_if.slave bus
);

  if (N_CH < 2 || N_CH > 16 || WIDTH < 1 || (MODE != 0 && MODE != 1)) begin : g_param_check
    $error("rr_stream_mux: illegal parameter set");
  end

  logic [CHW-1:0]    ptr;
  logic [CHW-1:0]    start_p0;
  logic [2*N_CH-2:0] dbl_p0;
  logic [N_CH-1:0]   rot_p0;
  logic              found_p0;
  logic [CHW-1:0]    offs_p0;
  logic [CHW:0]      sum_p0;
  logic [CHW-1:0]    gnt_idx_p0;
  logic [N_CH-1:0]   gnt_p0;
  logic [WIDTH-1:0]  data_p0;
  logic [CHW-1:0]    ptr_nxt_p0;
  logic              can_load;
  logic              xfer_p0;

  logic              vld_p1;
  logic [WIDTH-1:0]  data_p1;
  logic [CHW-1:0]    ch_p1;

  // ---- p0: combinational grant from in_valid and the round-robin pointer ----
  // Rotate the request vector so the search always starts at bit 0, then map the
  // winning offset back to an absolute channel index modulo N_CH.
  always_comb begin
    start_p0 = (MODE == 0) ? ptr : '0;
    dbl_p0   = {bus.in_valid[N_CH-2:0], bus.in_valid};
    rot_p0   = dbl_p0[N_CH-1:0];
    for (int s = 0; s < N_CH; s++) begin
      if (start_p0 == CHW'(s)) rot_p0 = dbl_p0[s +: N_CH];
    end

    found_p0 = 1'b0;
    offs_p0  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot_p0[k]) begin
        found_p0 = 1'b1;
        offs_p0  = CHW'(k);
      end
    end

    sum_p0 = {1'b0, start_p0} + {1'b0, offs_p0};
    if (sum_p0 >= (CHW+1)'(N_CH)) sum_p0 = sum_p0 - (CHW+1)'(N_CH);
    gnt_idx_p0 = sum_p0[CHW-1:0];
  end

  always_comb begin
    gnt_p0  = '0;
    data_p0 = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_idx_p0 == CHW'(k)) begin
        gnt_p0[k] = found_p0;
        data_p0   = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // The register may load when empty or when its word leaves on this same edge.
  assign can_load     = ~vld_p1 | bus.out_ready;
  assign xfer_p0      = found_p0 & can_load;
  assign bus.in_ready = gnt_p0 & {N_CH{can_load & areset_n}};
  assign ptr_nxt_p0   = (gnt_idx_p0 == CHW'(N_CH - 1)) ? '0 : gnt_idx_p0 + CHW'(1);

  // ---- p1: output register ----
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
      ptr     <= '0;
    end else if (xfer_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_p0;
      ch_p1   <= gnt_idx_p0;
      if (MODE == 0) ptr <= ptr_nxt_p0;
    end else if (bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_ch    = ch_p1;

endmodule
